serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial add/subtract sequencer built around the existing 1-bit full-adder cell FA_1, instantiated once. It accepts two WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first through the cell, one bit per clock. It accumulates the sum in a shift register and returns sum, carry-out and signed overflow over a second valid/ready handshake. It serves as the area-minimal arithmetic unit for the team's slow-path datapaths.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands; high only in IDLE
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in for add, borrow-in for subtract
in_sub  input  1  0 = A+B+cin, 1 = A-B-cin
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result
out_cout  output  1  final carry (for subtract: 1 = no borrow)
out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
busy  output  1  high in RUN or DONE

Behaviour:
- One clock. Reset is asynchronous, active-low, and takes effect immediately. While rst_n is low:
  - state = IDLE
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, busy = 0
  - in_ready = 1 (decoded from IDLE)
  - operand shift registers, carry register and bit counter = 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge, capture a_sh = in_a and b_sh = in_sub ? ~in_b : in_b.
  - Load the carry register with in_cin XOR in_sub.
  - Set count = 0 and go to RUN.
- RUN, each edge:
  - FA_1 inputs are a_sh[0], b_sh[0] and the carry register.
  - The FA sum bit shifts into the MSB of sum_sh; sum_sh shifts right.
  - a_sh and b_sh shift right; the carry register takes the FA carry-out; count increments.
  - On the edge that processes bit WIDTH-1, the pre-update carry register value is stored as c_msb_in.
  - After WIDTH edges in RUN, go to DONE.
  - in_ready = 0 throughout. in_valid is ignored; the source holds its request.
- DONE:
  - out_valid = 1, with out_sum = sum_sh, out_cout = carry register, out_ovf = c_msb_in XOR carry register.
  - All outputs are stable until the edge with out_valid & out_ready, then go to IDLE and clear out_valid.
  - No same-cycle accept of new operands; earliest new accept is the edge after the result handshake.
- Latency:
  - Operand accept at edge E; out_valid is seen high after edge E+WIDTH.
  - Throughput is one operation per WIDTH+2 cycles with out_ready held high.
- out_ready while out_valid = 0 is ignored.
- out_sum, out_cout and out_ovf are registered and change only on the entry to DONE or on reset.
- Arithmetic is modulo 2^WIDTH; out_cout is the bit-WIDTH carry.
- Reset mid-RUN or mid-DONE:
  - Abort immediately and return to the reset values above.
  - No partial result or residual carry survives.

Test Plan:
- WIDTH=8 add: in_a=0x3C, in_b=0x5A, cin=0, sub=0 -> out_sum=0x96, cout=0, ovf=1. out_valid rises exactly 8 edges after the accept edge; busy is high throughout.
- Add with wrap and carry-in: 0xFF+0x01, cin=0 -> 0x00, cout=1, ovf=0. Then 0x7F+0x00, cin=1 -> 0x80, cout=0, ovf=1.
- Subtract: 0x05-0x07, cin=0, sub=1 -> 0xFE, cout=0 (borrow), ovf=0. Then 0x80-0x01 -> 0x7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: outputs unchanged and in_ready=0 throughout; in_valid with new operands is not accepted.
  - Raise out_ready: out_valid drops next edge, in_ready=1 the following cycle.
- Mid-operation reset: pulse rst_n low after 3 RUN edges of 0xFF+0xFF.
  - Required: out_valid=0 and in_ready=1 asynchronously.
  - A following 0x01+0x01, cin=0 yields 0x02, cout=0 (no stale carry).
- Back-to-back operations with out_ready tied high and in_valid held: one result every 10 cycles. Results for 20 random add/sub vectors match a reference model.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer built on one FA_1 cell.
//
// Operands are accepted over an in_valid/in_ready handshake, fed LSB-first
// through a single full-adder cell one bit per clock, and the result is
// returned over an out_valid/out_ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in_a, in_b          WIDTH-bit operands
//   in_cin              carry-in (add) or borrow-in (subtract)
//   in_sub              0: A+B+cin, 1: A-B-cin
//   out_valid/out_ready result handshake
//   out_sum             WIDTH-bit result
//   out_cout            final carry (subtract: 1 = no borrow)
//   out_ovf             signed overflow
//   busy                high while an operation is in flight (RUN or DONE)

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, b_sh_q, sum_sh_q;
    logic              carry_q;
    logic              c_msb_q;
    logic [CntW-1:0]   count_q;
    logic [WIDTH-1:0]  out_sum_q;
    logic              out_cout_q;
    logic              out_ovf_q;

    logic fa_sum, fa_cout;
    logic accept, last_bit;

    FA_1 u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign accept   = (state_q == StIdle) && in_valid;
    assign last_bit = (state_q == StRun) && (count_q == LastBit);

    // Next-state and decoded outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun: begin
                busy = 1'b1;
                if (count_q == LastBit) state_d = StDone;
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            carry_q    <= 1'b0;
            c_msb_q    <= 1'b0;
            count_q    <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
        end else if (accept) begin
            a_sh_q   <= in_a;
            // Subtract as A + ~B + 1; borrow-in cancels that +1.
            b_sh_q   <= in_sub ? ~in_b : in_b;
            carry_q  <= in_cin ^ in_sub;
            sum_sh_q <= '0;
            count_q  <= '0;
        end else if (state_q == StRun) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
            carry_q  <= fa_cout;
            count_q  <= count_q + CntW'(1);
            if (last_bit) begin
                // Result registers load only on entry to DONE.
                c_msb_q    <= carry_q;
                out_sum_q  <= {fa_sum, sum_sh_q[WIDTH-1:1]};
                out_cout_q <= fa_cout;
                out_ovf_q  <= carry_q ^ fa_cout;
            end
        end
    end

    assign out_sum  = out_sum_q;
    assign out_cout = out_cout_q;
    assign out_ovf  = out_ovf_q;

endmodule

// FA_1: 1-bit full-adder cell.
//   a, b, cin   addend bits and carry-in
//   sum, cout   sum bit and carry-out
module FA_1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule
